// File: rtl/branch_cond_unit.sv
// Flag-driven control-flow unit: evaluates BRF/JMP/MOVF against the flag byte
// and owns the program counter, squashing issue slots after a taken branch.
module branch_cond_unit #(
   parameter int unsigned     PC_W         = 8,
   parameter logic [PC_W-1:0] RESET_PC     = '0,
   parameter int unsigned     FLUSH_CYCLES = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [7:0]      flags,
   input  logic            instr_valid,
   input  logic [4:0]      instr,
   input  logic [2:0]      s,
   input  logic            val,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc,
   output logic            taken,
   output logic            flush,
   output logic [7:0]      flags_rd,
   output logic            flags_rd_vld
);

   localparam logic [0:0] StRun   = 1'b0;
   localparam logic [0:0] StFlush = 1'b1;

   localparam logic [4:0] OpMovf = 5'h1A;
   localparam logic [4:0] OpBrf  = 5'h1B;
   localparam logic [4:0] OpJmp  = 5'h1C;

   localparam logic [2:0] FlushCnt = 3'(FLUSH_CYCLES);
   localparam bit         HasFlush = (FLUSH_CYCLES != 0);

   logic [0:0]      state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            taken_q, taken_d;
   logic            flush_q, flush_d;
   logic [7:0]      flags_rd_q, flags_rd_d;
   logic            vld_q, vld_d;
   logic            branch;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_d       = pc_q;
      taken_d    = 1'b0;
      flush_d    = flush_q;
      flags_rd_d = flags_rd_q;
      vld_d      = 1'b0;
      branch     = 1'b0;

      if (state_q == StFlush) begin
         // Squashed slot: no decode, pc holds until the count drains.
         cnt_d = cnt_q - 3'd1;
         if (cnt_q == 3'd1) begin
            state_d = StRun;
            flush_d = 1'b0;
         end
      end else if (instr_valid) begin
         case (instr)
            OpBrf:   branch = (flags[s] == val);
            OpJmp:   branch = 1'b1;
            OpMovf: begin
               if (val) begin
                  flags_rd_d = flags;
                  vld_d      = 1'b1;
               end
            end
            default: branch = 1'b0;
         endcase

         if (branch) begin
            pc_d    = target;
            taken_d = 1'b1;
            if (HasFlush) begin
               state_d = StFlush;
               cnt_d   = FlushCnt;
               flush_d = 1'b1;
            end
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StRun;
         cnt_q      <= 3'd0;
         pc_q       <= RESET_PC;
         taken_q    <= 1'b0;
         flush_q    <= 1'b0;
         flags_rd_q <= 8'h00;
         vld_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pc_q       <= pc_d;
         taken_q    <= taken_d;
         flush_q    <= flush_d;
         flags_rd_q <= flags_rd_d;
         vld_q      <= vld_d;
      end
   end

   assign pc           = pc_q;
   assign taken        = taken_q;
   assign flush        = flush_q;
   assign flags_rd     = flags_rd_q;
   assign flags_rd_vld = vld_q;

endmodule
